// File: rtl/sprite_plotter.sv
// rtl/sprite_plotter.sv - renders a SIZE_W x SIZE_H sprite or a full-screen clear into the VGA write port
module sprite_plotter #(
    parameter int         SIZE_W    = 4,
    parameter int         SIZE_H    = 4,
    parameter logic [2:0] FG_COLOUR = 3'b111,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter int         X_MAX     = 159,
    parameter int         Y_MAX     = 119
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] x_in,
    input  logic [6:0] y_in,
    input  logic       undraw_in,
    input  logic       clear_req,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       done
);

    localparam logic [8:0] X_LIM      = 9'(X_MAX);
    localparam logic [7:0] Y_LIM      = 8'(Y_MAX);
    localparam logic [7:0] CX_LAST    = 8'(SIZE_W - 1);
    localparam logic [6:0] CY_LAST    = 7'(SIZE_H - 1);
    localparam logic [7:0] CLR_X_LAST = 8'(X_MAX);
    localparam logic [6:0] CLR_Y_LAST = 7'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PLOT,
        S_CLEAR,
        S_DONE
    } state_t;

    state_t     state, state_d;
    logic [7:0] cx, cx_d;
    logic [6:0] cy, cy_d;
    logic [7:0] snap_x, snap_x_d;
    logic [6:0] snap_y, snap_y_d;
    logic       snap_u, snap_u_d;
    logic       snap_valid, snap_valid_d;
    logic       clear_pend, clear_pend_d;

    logic [7:0] vga_x_d;
    logic [6:0] vga_y_d;
    logic [2:0] vga_colour_d;
    logic       vga_plot_d, busy_d, done_d;

    logic       change;
    logic [8:0] x_sum;
    logic [7:0] y_sum;

    assign change = !snap_valid || ({x_in, y_in, undraw_in} != {snap_x, snap_y, snap_u});
    assign x_sum  = {1'b0, snap_x} + {1'b0, cx};
    assign y_sum  = {1'b0, snap_y} + {1'b0, cy};

    always_comb begin
        state_d      = state;
        cx_d         = cx;
        cy_d         = cy;
        snap_x_d     = snap_x;
        snap_y_d     = snap_y;
        snap_u_d     = snap_u;
        snap_valid_d = snap_valid;
        // A request arriving during a clear is absorbed by the clear in progress
        clear_pend_d = clear_pend | (clear_req && state != S_CLEAR);
        vga_x_d      = vga_x;
        vga_y_d      = vga_y;
        vga_colour_d = vga_colour;
        vga_plot_d   = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;

        case (state)
            S_IDLE: begin
                // Clear wins over a pending move, including a request sampled this cycle
                if (clear_pend || clear_req) begin
                    state_d      = S_CLEAR;
                    clear_pend_d = 1'b0;
                    cx_d         = '0;
                    cy_d         = '0;
                end else if (change) begin
                    state_d      = S_PLOT;
                    snap_x_d     = x_in;
                    snap_y_d     = y_in;
                    snap_u_d     = undraw_in;
                    snap_valid_d = 1'b1;
                    cx_d         = '0;
                    cy_d         = '0;
                end
            end

            S_PLOT: begin
                vga_x_d      = x_sum[7:0];
                vga_y_d      = y_sum[6:0];
                vga_colour_d = snap_u ? BG_COLOUR : FG_COLOUR;
                vga_plot_d   = (x_sum <= X_LIM) && (y_sum <= Y_LIM);
                busy_d       = 1'b1;
                if (cx == CX_LAST) begin
                    cx_d = '0;
                    if (cy == CY_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        cy_d = cy + 7'd1;
                    end
                end else begin
                    cx_d = cx + 8'd1;
                end
            end

            S_CLEAR: begin
                vga_x_d      = cx;
                vga_y_d      = cy;
                vga_colour_d = BG_COLOUR;
                vga_plot_d   = 1'b1;
                busy_d       = 1'b1;
                if (cx == CLR_X_LAST) begin
                    cx_d = '0;
                    if (cy == CLR_Y_LAST) begin
                        snap_valid_d = 1'b0;
                        state_d      = S_DONE;
                    end else begin
                        cy_d = cy + 7'd1;
                    end
                end else begin
                    cx_d = cx + 8'd1;
                end
            end

            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cx         <= '0;
            cy         <= '0;
            snap_x     <= '0;
            snap_y     <= '0;
            snap_u     <= 1'b0;
            snap_valid <= 1'b0;
            clear_pend <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            cx         <= cx_d;
            cy         <= cy_d;
            snap_x     <= snap_x_d;
            snap_y     <= snap_y_d;
            snap_u     <= snap_u_d;
            snap_valid <= snap_valid_d;
            clear_pend <= clear_pend_d;
            vga_x      <= vga_x_d;
            vga_y      <= vga_y_d;
            vga_colour <= vga_colour_d;
            vga_plot   <= vga_plot_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_sprite_plotter.sv
// tb/tb_sprite_plotter.sv - self-checking bench for sprite_plotter against a pixel-list reference model
module tb_sprite_plotter;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int XM = 159;
    localparam int YM = 119;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] x_in = '0;
    logic [6:0] y_in = '0;
    logic       undraw_in = 1'b0;
    logic       clear_req = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    // Reference view of what the plotter last rendered
    logic [7:0] ref_x;
    logic [6:0] ref_y;
    logic       ref_u;
    bit         have_snap = 1'b0;

    logic [7:0] nx;
    logic [6:0] ny;
    logic       nu;
    int         ca;

    sprite_plotter #(
        .SIZE_W(W), .SIZE_H(H), .FG_COLOUR(3'b111), .BG_COLOUR(3'b000), .X_MAX(XM), .Y_MAX(YM)
    ) dut (
        .clock(clock), .reset_n(reset_n), .x_in(x_in), .y_in(y_in), .undraw_in(undraw_in),
        .clear_req(clear_req), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, busy, done, vga_plot, vga_colour, vga_x, vga_y};
    endfunction

    function automatic logic [31:0] status();
        return {29'd0, busy, done, vga_plot};
    endfunction

    function automatic logic [31:0] exp_pixel(input int sx, input int sy, input bit su,
                                              input int px, input int py);
        int  xs, ys;
        bit  vis;
        logic [7:0] ex;
        logic [6:0] ey;
        xs  = sx + px;
        ys  = sy + py;
        vis = (xs <= XM) && (ys <= YM);
        ex  = 8'(xs);
        ey  = 7'(ys);
        return {11'd0, 1'b1, 1'b0, vis, (su ? 3'b000 : 3'b111), ex, ey};
    endfunction

    function automatic bit pending();
        return !have_snap || ({x_in, y_in, undraw_in} != {ref_x, ref_y, ref_u});
    endfunction

    // Expects one render of the inputs present now: one latch cycle, W*H pixels, done.
    task automatic expect_render(input int chg_at, input logic [7:0] chg_x, input bit chg_clr,
                                 input int abort_at);
        int sx, sy, k;
        bit su;
        sx = x_in;
        sy = y_in;
        su = undraw_in;
        step();
        check("latch", status(), 32'h0);
        k = 0;
        for (int py = 0; py < H; py++) begin
            for (int px = 0; px < W; px++) begin
                if (k == chg_at) begin
                    x_in = chg_x;
                    clear_req = chg_clr;
                end
                if (k == abort_at) begin
                    reset_n = 1'b0;
                    step();
                    check("reset_mid", outs(), 32'h0);
                    reset_n = 1'b1;
                    have_snap = 1'b0;
                    return;
                end
                step();
                clear_req = 1'b0;
                check("pixel", outs(), exp_pixel(sx, sy, su, px, py));
                k++;
            end
        end
        step();
        check("done", status(), 32'h2);
        ref_x = 8'(sx);
        ref_y = 7'(sy);
        ref_u = su;
        have_snap = 1'b1;
    endtask

    task automatic expect_clear();
        step();
        clear_req = 1'b0;
        check("clr_latch", status(), 32'h0);
        for (int py = 0; py <= YM; py++) begin
            for (int px = 0; px <= XM; px++) begin
                step();
                check("clr_pixel", outs(), {11'd0, 1'b1, 1'b0, 1'b1, 3'b000, 8'(px), 7'(py)});
            end
        end
        step();
        check("clr_done", status(), 32'h2);
        have_snap = 1'b0;
    endtask

    task automatic expect_idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check("idle", status(), 32'h0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        x_in = 8'd5;
        y_in = 7'd5;
        undraw_in = 1'b0;
        step();
        step();
        check("reset", outs(), 32'h0);
        reset_n = 1'b1;

        // Draw, idle hold, erase in place
        expect_render(-1, 8'd0, 1'b0, -1);
        expect_idle(5);
        undraw_in = 1'b1;
        expect_render(-1, 8'd0, 1'b0, -1);
        expect_idle(2);

        // Bottom-right clipping
        x_in = 8'd158;
        y_in = 7'd118;
        undraw_in = 1'b0;
        expect_render(-1, 8'd0, 1'b0, -1);
        expect_idle(2);

        // Move during a render: only the latest position follows
        x_in = 8'd5;
        y_in = 7'd5;
        expect_render(5, 8'd9, 1'b0, -1);
        expect_render(-1, 8'd0, 1'b0, -1);
        expect_idle(2);

        // Clear and move together: clear first, then redraw
        clear_req = 1'b1;
        x_in = 8'd20;
        expect_clear();
        expect_render(-1, 8'd0, 1'b0, -1);
        expect_idle(2);

        // Clear requested mid-render is deferred until the render finishes
        x_in = 8'd40;
        expect_render(3, 8'd41, 1'b1, -1);
        expect_clear();
        expect_render(-1, 8'd0, 1'b0, -1);
        expect_idle(2);

        // Reset mid-render forces a full redraw of the same inputs
        x_in = 8'd30;
        y_in = 7'd30;
        expect_render(-1, 8'd0, 1'b0, 8);
        expect_render(-1, 8'd0, 1'b0, -1);
        expect_idle(2);

        for (int i = 0; i < 40; i++) begin
            nx = 8'($urandom_range(0, 170));
            ny = 7'($urandom_range(0, 127));
            nu = 1'($urandom_range(0, 1));
            if (have_snap && ({nx, ny, nu} == {ref_x, ref_y, ref_u})) nu = ~nu;
            x_in = nx;
            y_in = ny;
            undraw_in = nu;
            ca = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W * H - 1)) : -1;
            expect_render(ca, 8'($urandom_range(0, 170)), 1'b0, -1);
            while (pending()) expect_render(-1, 8'd0, 1'b0, -1);
            expect_idle(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
